dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Single-port data-memory arbiter that shares the pipeline CPU's data memory between the CPU load/store stage and a debug/loader requester (UART command engine). CPU has fixed priority; a starvation counter guarantees the debug port a slot, and a lock lets the debug port perform uninterrupted multi-word sequences. Sits between the CPU memory stage, the UART debug engine and the data memory array (synchronous read, 1-cycle latency).

## Interface
Parameters:
- ADDR_W, 5, word address width (32-word data memory)
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied debug-request cycles before a forced debug grant (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same meaning as CPU
- dbg_lock  in  1  hold ownership after grant while high
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug grant/read-valid/read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en with mem_we=0
- cpu_stall  out  1  cpu_req high and cpu_gnt low

## Operation
- States: PRIO (default), FORCE, LOCK.
- PRIO: cpu_req=1 -> CPU granted; else dbg_req=1 -> debug granted; else idle.
- Starve counter (8 bit): in PRIO, increments each cycle dbg_req=1 and dbg_gnt=0; clears when dbg_gnt=1 or dbg_req=0. Counter reaching STARVE_LIMIT -> next state FORCE.
- FORCE: lasts exactly one cycle; debug granted if dbg_req=1 (CPU denied even if requesting); counter cleared; if dbg_req dropped, CPU arbitrates normally that cycle. Next state PRIO, or LOCK if debug granted with dbg_lock=1.
- Debug grant with dbg_lock=1 (PRIO or FORCE) -> LOCK next cycle.
- LOCK: only debug may be granted (when dbg_req=1); cpu_gnt=0; exit to PRIO in the cycle after dbg_lock samples 0. Counter held at 0.
- At most one of cpu_gnt/dbg_gnt high in any cycle. mem_en = cpu_gnt|dbg_gnt; mem_we/addr/wdata muxed from winner; zero when idle.
- Requesters hold req/we/addr/wdata stable until gnt; each gnt cycle is one completed access.
- Read return: owner-of-read tag registered at grant; next cycle corresponding *_rvalid=1 and *_rdata=mem_rdata; non-owner rdata=0. Writes produce no rvalid.

## Timing
- Grants are combinational from req and current state: zero-cycle grant latency.
- Read latency: rvalid exactly 1 cycle after the granted read; back-to-back reads sustain 1 access/cycle.
- Reset (async assert, sync deassert sampled at clk): state PRIO, counter 0, both rvalid 0; all outputs 0 while rst_n=0 except gnt/mem_* which follow combinational rules with state PRIO (forced 0 while rst_n=0). Pending read return is discarded when reset hits mid-access.
- Simultaneous requests in PRIO with counter<STARVE_LIMIT: CPU wins.
- STARVE_LIMIT reached in the same cycle CPU releases: debug granted in PRIO that cycle; FORCE not entered.

## Test plan
- Reset: rst_n low mid-read (cpu read granted) -> cpu_rvalid stays 0 next cycle, cpu_gnt=dbg_gnt=0 during reset.
- CPU-only read addr 3, memory holds 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid=1 with 0xDEADBEEF next cycle, dbg_rvalid=0.
- Both request continuously, STARVE_LIMIT=8 -> dbg_gnt first high at cycle 9 of contention (FORCE), cpu_stall=1 that cycle, then CPU again; pattern repeats every 9 cycles.
- Debug lock: dbg write 0x11 to addr 0 with dbg_lock=1, then write addr 1, CPU requesting throughout -> cpu_gnt=0 until cycle after dbg_lock falls; both words present in memory.
- Idle debug after lock: dbg_lock=1 but dbg_req=0 for 3 cycles -> mem_en=0, cpu stalled, counter stays 0.
- Interleaved: cpu read addr 2 then dbg read addr 5 consecutive cycles -> cpu_rvalid then dbg_rvalid on successive cycles with correct data routed.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side data-memory access port: request/grant plus read return.
// Latency: pure wiring, no state.
// Backpressure: requester holds req/we/addr/wdata until gnt is seen high.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester drives the access, arbiter answers with grant and read data.
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data memory between the CPU and a debug requester.
// Latency: grant is combinational; read data returns one cycle after grant.
// Backpressure: a denied requester sees gnt low and must hold its request.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_arbiter_if.slave cpu,
  dmem_port_arbiter_if.slave dbg,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    ST_PRIO  = 2'd0,
    ST_FORCE = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       cpu_rd_q, cpu_rd_d;
  logic       dbg_rd_q, dbg_rd_d;
  logic       cpu_gnt, dbg_gnt;

  // Arbitration: pick the winner for this cycle and the next mode.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    case (state_q)
      ST_PRIO: begin
        cpu_gnt = cpu.req;
        dbg_gnt = dbg.req & ~cpu.req;
        // Only a debug request that is actually refused counts as starving.
        if (dbg.req && !dbg_gnt) starve_d = starve_q + 8'd1;
        else                     starve_d = 8'd0;
        if (dbg_gnt && dbg_lock)                 state_d = ST_LOCK;
        else if (starve_d >= 8'(STARVE_LIMIT))   state_d = ST_FORCE;
      end
      ST_FORCE: begin
        // One guaranteed debug slot; CPU only gets it if debug went away.
        dbg_gnt  = dbg.req;
        cpu_gnt  = cpu.req & ~dbg.req;
        starve_d = 8'd0;
        state_d  = (dbg_gnt && dbg_lock) ? ST_LOCK : ST_PRIO;
      end
      ST_LOCK: begin
        // Debug owns the memory until it drops the lock, even when idle.
        dbg_gnt  = dbg.req;
        starve_d = 8'd0;
        state_d  = dbg_lock ? ST_LOCK : ST_PRIO;
      end
      default: begin
        state_d  = ST_PRIO;
        starve_d = 8'd0;
      end
    endcase
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
    cpu_rd_d = cpu_gnt & ~cpu.we;
    dbg_rd_d = dbg_gnt & ~dbg.we;
  end

  // State, starvation counter and read-owner tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PRIO;
      starve_q <= 8'd0;
      cpu_rd_q <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cpu_rd_q <= cpu_rd_d;
      dbg_rd_q <= dbg_rd_d;
    end
  end

  // Memory command mux; all fields zero when nobody is granted.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu.we;
      mem_addr  = cpu.addr;
      mem_wdata = cpu.wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg.we;
      mem_addr  = dbg.addr;
      mem_wdata = dbg.wdata;
    end
  end

  assign cpu.gnt    = cpu_gnt;
  assign dbg.gnt    = dbg_gnt;
  assign cpu.rvalid = cpu_rd_q;
  assign dbg.rvalid = dbg_rd_q;
  assign cpu.rdata  = cpu_rd_q ? mem_rdata : '0;
  assign dbg.rdata  = dbg_rd_q ? mem_rdata : '0;
  assign cpu_stall  = rst_n & cpu.req & ~cpu_gnt;

endmodule
